// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider with generic width, per-operation signed/unsigned mode,
// one-cycle done strobe and divide-by-zero / signed-overflow flags. One operation in flight.
module seq_divider_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_en,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;       // dividend magnitude, shifts out MSB-first, collects quotient bits
    logic [WIDTH-1:0] dvs;       // divisor magnitude
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dz_pend;
    logic             ovf_pend;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;

    // Magnitudes of the incoming operands; MIN maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        a_neg = signed_en & in_a[WIDTH-1];
        b_neg = signed_en & in_b[WIDTH-1];
        a_mag = a_neg ? -in_a : in_a;
        b_mag = b_neg ? -in_b : in_b;
    end

    // One restoring step: compare instead of checking a borrow bit, so WIDTH+1 bits suffice.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs});
        diff    = shifted - {1'b0, dvs};
    end

    // NOTE: registers use non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz_pend   <= 1'b0;
            ovf_pend  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd      <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        dz_pend  <= (in_b == '0);
                        ovf_pend <= signed_en && (in_a == MIN_VAL) && (in_b == '1);
                        div_zero <= 1'b0;
                        overflow <= 1'b0;
                        if (in_b == '0) begin
                            state <= DONE;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_W'(WIDTH);
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd <= {dvd[WIDTH-2:0], ge};
                    rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    if (dz_pend) begin
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        quotient  <= neg_q ? -dvd : dvd;
                        remainder <= neg_r ? -rem : rem;
                    end
                    div_zero <= dz_pend;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider_param.sv
// Directed bench for seq_divider_param: WIDTH=8 unsigned/signed/zero/abort cases
// and a WIDTH=16 instance, each compared against hand-computed results.
module tb_seq_divider_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, signed_en;
    logic [7:0]  in_a, in_b, quotient, remainder;
    logic        busy, done, div_zero, overflow;

    logic        start_w, signed_en_w;
    logic [15:0] in_a_w, in_b_w, quotient_w, remainder_w;
    logic        busy_w, done_w, div_zero_w, overflow_w;

    int checks = 0;
    int errors = 0;
    int edges, busy_cycles, seen;

    always #5 clk = ~clk;

    seq_divider_param #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_en(signed_en),
        .in_a(in_a), .in_b(in_b), .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .div_zero(div_zero), .overflow(overflow)
    );

    seq_divider_param #(.WIDTH(16)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .signed_en(signed_en_w),
        .in_a(in_a_w), .in_b(in_b_w), .quotient(quotient_w), .remainder(remainder_w),
        .busy(busy_w), .done(done_w), .div_zero(div_zero_w), .overflow(overflow_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one 8-bit operation and counts edges after the accepting edge until done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input bit mid_pulse, output int n_edges, output int n_busy);
        @(negedge clk);
        in_a = a; in_b = b; signed_en = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_edges = -1;
        n_busy = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            if (mid_pulse && i == 3) begin
                in_a = 8'd100; in_b = 8'd3; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) n_busy++;
            if (done) begin
                n_edges = i;
                break;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [7:0] q, input logic [7:0] r,
                            input logic dz, input logic ovf, input int exp_edges, input int exp_busy);
        check({tag, " latency"}, edges, exp_edges);
        check({tag, " busy cycles"}, busy_cycles, exp_busy);
        check({tag, " quotient"}, quotient, q);
        check({tag, " remainder"}, remainder, r);
        check({tag, " div_zero"}, div_zero, dz);
        check({tag, " overflow"}, overflow, ovf);
        @(posedge clk); #1;
        check({tag, " done one cycle"}, done, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; signed_en = 1'b0; in_a = '0; in_b = '0;
        start_w = 1'b0; signed_en_w = 1'b0; in_a_w = '0; in_b_w = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset quotient", quotient, 8'h00);
        check("reset remainder", remainder, 8'h00);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset flags", {div_zero, overflow}, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        run_op(8'd17, 8'd8, 1'b0, 1'b0, edges, busy_cycles);
        check_op("u 17/8", 8'd2, 8'd1, 1'b0, 1'b0, 9, 8);
        run_op(8'd12, 8'd15, 1'b0, 1'b0, edges, busy_cycles);
        check_op("u 12/15", 8'd0, 8'd12, 1'b0, 1'b0, 9, 8);
        run_op(8'd0, 8'd13, 1'b0, 1'b0, edges, busy_cycles);
        check_op("u 0/13", 8'd0, 8'd0, 1'b0, 1'b0, 9, 8);
        run_op(8'd255, 8'd15, 1'b0, 1'b0, edges, busy_cycles);
        check_op("u 255/15", 8'd17, 8'd0, 1'b0, 1'b0, 9, 8);
        run_op(8'd40, 8'd0, 1'b0, 1'b0, edges, busy_cycles);
        check_op("u 40/0", 8'd0, 8'd0, 1'b1, 1'b0, 1, 0);
        run_op(8'd0, 8'd0, 1'b1, 1'b0, edges, busy_cycles);
        check_op("s 0/0", 8'd0, 8'd0, 1'b1, 1'b0, 1, 0);

        run_op(8'hEF, 8'd5, 1'b1, 1'b0, edges, busy_cycles);
        check_op("s -17/5", 8'hFD, 8'hFE, 1'b0, 1'b0, 9, 8);
        run_op(8'd17, 8'hFB, 1'b1, 1'b0, edges, busy_cycles);
        check_op("s 17/-5", 8'hFD, 8'h02, 1'b0, 1'b0, 9, 8);
        run_op(8'h80, 8'hFF, 1'b1, 1'b0, edges, busy_cycles);
        check_op("s -128/-1", 8'h80, 8'h00, 1'b0, 1'b1, 9, 8);
        run_op(8'h80, 8'hFF, 1'b0, 1'b0, edges, busy_cycles);
        check_op("u 128/255", 8'h00, 8'h80, 1'b0, 1'b0, 9, 8);

        // Abort an operation four cycles into CALC.
        @(negedge clk);
        in_a = 8'd213; in_b = 8'd8; signed_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort busy before reset", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort quotient", quotient, 8'h00);
        check("abort remainder", remainder, 8'h00);
        check("abort busy", busy, 1'b0);
        check("abort flags", {done, div_zero, overflow}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("abort no done", seen, 0);

        run_op(8'd13, 8'd5, 1'b0, 1'b1, edges, busy_cycles);
        check_op("u 13/5 mid-start", 8'd2, 8'd3, 1'b0, 1'b0, 9, 8);

        // WIDTH=16 instance.
        @(negedge clk);
        in_a_w = 16'd65535; in_b_w = 16'd255; signed_en_w = 1'b0; start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0;
        edges = -1;
        busy_cycles = busy_w ? 1 : 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (busy_w) busy_cycles++;
            if (done_w) begin
                edges = i;
                break;
            end
        end
        check("w16 latency", edges, 17);
        check("w16 busy cycles", busy_cycles, 16);
        check("w16 quotient", quotient_w, 16'd257);
        check("w16 remainder", remainder_w, 16'd0);
        check("w16 flags", {div_zero_w, overflow_w}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
